// File: rtl/sa_pkg.sv
// Shared defaults and helpers for the systolic-array requantization path.
//   - *_DEF localparams: default widths used by sa_requant and its lanes.
//   - SAT_CNT_WIDTH: width of the saturation event counter.
//   - SAT_MAX/SAT_MIN: signed clamp limits for a BITWIDTH-bit output.
package sa_pkg;

  localparam int unsigned LANES_DEF       = 4;
  localparam int unsigned ACC_WIDTH_DEF   = 32;
  localparam int unsigned MULT_WIDTH_DEF  = 16;
  localparam int unsigned SHIFT_WIDTH_DEF = 6;
  localparam int unsigned BITWIDTH_DEF    = 8;
  localparam int unsigned SAT_CNT_WIDTH   = 16;

  function automatic longint SAT_MAX(input int unsigned bw);
    return (longint'(1) <<< (bw - 1)) - 1;
  endfunction

  function automatic longint SAT_MIN(input int unsigned bw);
    return -(longint'(1) <<< (bw - 1));
  endfunction

endpackage

// File: rtl/sa_requant_lane.sv
// One lane of the requantization datapath.
//   S1: prod   = acc * mult                      (ACC_WIDTH+MULT_WIDTH bits)
//   S2: shr    = (prod + round(shift)) >>> shift  (one extra bit)
//   S3: result = clamp(shr) to signed BITWIDTH
// Ports:
//   clk_i, rst_n_i       clock, async active-low reset (result register only)
//   s1/s2/s3_load_i      stage load strobes from the top-level handshake
//   acc_i, mult_i        accumulator input and scale captured at S1 entry
//   shift_i              shift carried with the beat currently held in S1
//   sat_o                lane clamps the value currently entering S3
//   result_o             registered, saturated lane output
module sa_requant_lane
  import sa_pkg::*;
#(
  parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int unsigned MULT_WIDTH  = MULT_WIDTH_DEF,
  parameter int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int unsigned BITWIDTH    = BITWIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          s1_load_i,
  input  logic                          s2_load_i,
  input  logic                          s3_load_i,
  input  logic signed [ACC_WIDTH-1:0]   acc_i,
  input  logic signed [MULT_WIDTH-1:0]  mult_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  output logic                          sat_o,
  output logic signed [BITWIDTH-1:0]    result_o
);

  localparam int unsigned PW = ACC_WIDTH + MULT_WIDTH;
  localparam int unsigned SW = PW + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'(SAT_MAX(BITWIDTH));
  localparam logic signed [SW-1:0] MIN_V = SW'(SAT_MIN(BITWIDTH));

  logic signed [PW-1:0]       prod_d, prod_q;
  logic signed [SW-1:0]       shr_d, shr_q;
  logic signed [SW-1:0]       rnd, sum;
  logic signed [BITWIDTH-1:0] result_d, result_q;
  logic                       sat_hi, sat_lo;

  always_comb begin
    prod_d = PW'(acc_i) * PW'(mult_i);

    // Round half up before the arithmetic shift; no rounding term for shift 0.
    rnd = '0;
    if (shift_i != '0) begin
      rnd = SW'(1) <<< (shift_i - SHIFT_WIDTH'(1));
    end
    sum   = SW'(prod_q) + rnd;
    shr_d = sum >>> shift_i;

    sat_hi = shr_q > MAX_V;
    sat_lo = shr_q < MIN_V;
    sat_o  = sat_hi | sat_lo;
    if (sat_hi) begin
      result_d = MAX_V[BITWIDTH-1:0];
    end else if (sat_lo) begin
      result_d = MIN_V[BITWIDTH-1:0];
    end else begin
      result_d = shr_q[BITWIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (s1_load_i) prod_q <= prod_d;
    if (s2_load_i) shr_q  <= shr_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      result_q <= '0;
    end else if (s3_load_i) begin
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/sa_requant.sv
// Requantization stage ahead of the ReLU: per lane (acc*mult + round) >>> shift,
// then saturate to signed BITWIDTH. Three-stage pipeline, valid/ready both sides.
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   cfg_we_i                  load mult/shift shadow regs, clear saturation counter
//   cfg_mult_i, cfg_shift_i   signed scale, unsigned arithmetic right shift
//   in_valid_i, in_ready_o    input handshake
//   data_i                    LANES signed accumulators, lane k at [k*ACC_WIDTH +: ACC_WIDTH]
//   out_valid_o, out_ready_i  output handshake
//   result_o                  LANES signed results, lane k at [k*BITWIDTH +: BITWIDTH]
//   sat_cnt_o                 number of clamped lanes, sticks at all-ones
module sa_requant
  import sa_pkg::*;
#(
  parameter int unsigned LANES       = LANES_DEF,
  parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int unsigned MULT_WIDTH  = MULT_WIDTH_DEF,
  parameter int unsigned SHIFT_WIDTH = SHIFT_WIDTH_DEF,
  parameter int unsigned BITWIDTH    = BITWIDTH_DEF
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         cfg_we_i,
  input  logic [MULT_WIDTH-1:0]        cfg_mult_i,
  input  logic [SHIFT_WIDTH-1:0]       cfg_shift_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [LANES*ACC_WIDTH-1:0]   data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [LANES*BITWIDTH-1:0]    result_o,
  output logic [SAT_CNT_WIDTH-1:0]     sat_cnt_o
);

  logic signed [MULT_WIDTH-1:0] mult_d, mult_q;
  logic [SHIFT_WIDTH-1:0]       shift_d, shift_q;
  logic [SHIFT_WIDTH-1:0]       s1_shift_d, s1_shift_q;
  logic                         s1_valid_d, s1_valid_q;
  logic                         s2_valid_d, s2_valid_q;
  logic                         s3_valid_d, s3_valid_q;
  logic [SAT_CNT_WIDTH-1:0]     sat_cnt_d, sat_cnt_q;
  logic [SAT_CNT_WIDTH:0]       sat_inc, sat_sum;
  logic [LANES-1:0]             sat_lane;
  logic                         s1_adv, s2_adv, s3_adv;
  logic                         s1_load, s2_load, s3_load;

  always_comb begin
    s3_adv  = !s3_valid_q | out_ready_i;
    s2_adv  = !s2_valid_q | s3_adv;
    s1_adv  = !s1_valid_q | s2_adv;
    s1_load = in_valid_i & s1_adv;
    s2_load = s1_valid_q & s2_adv;
    s3_load = s2_valid_q & s3_adv;

    s1_valid_d = s1_adv ? in_valid_i : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s3_valid_d = s3_adv ? s2_valid_q : s3_valid_q;

    // The beat captures the live shift on S1 entry so later cfg writes cannot touch it.
    s1_shift_d = s1_load ? shift_q : s1_shift_q;

    mult_d  = cfg_we_i ? cfg_mult_i  : mult_q;
    shift_d = cfg_we_i ? cfg_shift_i : shift_q;

    sat_inc = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sat_inc = sat_inc + (SAT_CNT_WIDTH+1)'(sat_lane[i]);
    end
    sat_sum = {1'b0, sat_cnt_q} + sat_inc;

    // A config write clears the counter even if a beat is entering S3 in the same cycle.
    sat_cnt_d = sat_cnt_q;
    if (cfg_we_i) begin
      sat_cnt_d = '0;
    end else if (s3_load) begin
      sat_cnt_d = sat_sum[SAT_CNT_WIDTH] ? '1 : sat_sum[SAT_CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      mult_q     <= MULT_WIDTH'(1);
      shift_q    <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
      mult_q     <= mult_d;
      shift_q    <= shift_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    s1_shift_q <= s1_shift_d;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sa_requant_lane #(
      .ACC_WIDTH  (ACC_WIDTH),
      .MULT_WIDTH (MULT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH),
      .BITWIDTH   (BITWIDTH)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .s1_load_i(s1_load),
      .s2_load_i(s2_load),
      .s3_load_i(s3_load),
      .acc_i    (data_i[k*ACC_WIDTH +: ACC_WIDTH]),
      .mult_i   (mult_q),
      .shift_i  (s1_shift_q),
      .sat_o    (sat_lane[k]),
      .result_o (result_o[k*BITWIDTH +: BITWIDTH])
    );
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s3_valid_q;
  assign sat_cnt_o   = sat_cnt_q;

endmodule

// File: tb/tb_sa_requant.sv
module tb_sa_requant;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         cfg_we_i;
  logic [15:0]  cfg_mult_i;
  logic [5:0]   cfg_shift_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] data_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [31:0]  result_o;
  logic [15:0]  sat_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  int nxt, got;
  logic acc_f, took_f;

  always #5 clk_i = ~clk_i;

  sa_requant #(
    .LANES      (4),
    .ACC_WIDTH  (32),
    .MULT_WIDTH (16),
    .SHIFT_WIDTH(6),
    .BITWIDTH   (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_mult_i (cfg_mult_i),
    .cfg_shift_i(cfg_shift_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .data_i     (data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .result_o   (result_o),
    .sat_cnt_o  (sat_cnt_o)
  );

  function automatic logic [127:0] pk_acc(input int a0, input int a1, input int a2, input int a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [31:0] pk_res(input int r0, input int r1, input int r2, input int r3);
    return {8'(r3), 8'(r2), 8'(r1), 8'(r0)};
  endfunction

  function automatic logic [127:0] beat_acc(input int b);
    return pk_acc(10*b+1, 10*b+2, 10*b+3, 10*b+4);
  endfunction

  function automatic logic [31:0] beat_res(input int b);
    return pk_res(10*b+1, 10*b+2, 10*b+3, 10*b+4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfg(input int m, input int s);
    cfg_mult_i  = 16'(m);
    cfg_shift_i = 6'(s);
    cfg_we_i    = 1'b1;
    step();
    cfg_we_i    = 1'b0;
  endtask

  // One beat, out_ready held high: visible on the third edge after it is presented.
  task automatic send_check(input string tag, input logic [127:0] acc, input logic [31:0] exp,
                            input logic [15:0] exp_sat);
    data_i     = acc;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid_o), 64'd0);
    step();
    chk({tag, "_lat2"}, 64'(out_valid_o), 64'd0);
    step();
    chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    chk({tag, "_result"}, 64'(result_o), 64'(exp));
    chk({tag, "_satcnt"}, 64'(sat_cnt_o), 64'(exp_sat));
    step();
    chk({tag, "_drain"}, 64'(out_valid_o), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_i     = 1'b0;
    cfg_we_i    = 1'b0;
    cfg_mult_i  = '0;
    cfg_shift_i = '0;
    in_valid_i  = 1'b0;
    data_i      = '0;
    out_ready_i = 1'b1;
    step();
    step();
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_sat_cnt", 64'(sat_cnt_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    rst_n_i = 1'b1;
    step();

    // Reset config is mult=1 shift=0.
    send_check("t1", pk_acc(5, -5, 127, -128), pk_res(5, -5, 127, -128), 16'd0);
    send_check("t2", pk_acc(300, -300, 128, -129), pk_res(127, -128, 127, -128), 16'd4);

    cfg(3, 2);
    chk("cfg_clear", 64'(sat_cnt_o), 64'd0);
    send_check("t3", pk_acc(5, -5, 6, 0), pk_res(4, -4, 5, 0), 16'd0);

    // Stall: out_ready low for 6 cycles while 5 beats are offered.
    cfg(1, 0);
    nxt = 0;
    got = 0;
    in_valid_i = 1'b1;
    data_i = beat_acc(0);
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      out_ready_i = (cyc >= 6);
      #1;
      if (cyc >= 3 && cyc < 6) begin
        chk("stall_valid", 64'(out_valid_o), 64'd1);
        chk("stall_hold", 64'(result_o), 64'(beat_res(0)));
      end
      if (cyc == 5) begin
        chk("stall_accepted", 64'(nxt), 64'd3);
        chk("stall_in_ready", 64'(in_ready_o), 64'd0);
      end
      acc_f  = in_valid_i & in_ready_o;
      took_f = out_valid_o & out_ready_i;
      if (took_f) begin
        chk("stall_order", 64'(result_o), 64'(beat_res(got)));
        got++;
      end
      step();
      if (acc_f) begin
        nxt++;
        if (nxt < 5) data_i = beat_acc(nxt);
        else in_valid_i = 1'b0;
      end
    end
    chk("stall_delivered", 64'(got), 64'd5);
    chk("stall_accepted_all", 64'(nxt), 64'd5);
    step();
    chk("stall_empty", 64'(out_valid_o), 64'd0);

    // Config write with two beats in flight; it coincides with beat A entering S3.
    in_valid_i = 1'b1;
    data_i = pk_acc(200, 2, 3, 4);
    step();
    data_i = pk_acc(5, 6, 7, 8);
    step();
    in_valid_i  = 1'b0;
    cfg_mult_i  = 16'd2;
    cfg_shift_i = 6'd0;
    cfg_we_i    = 1'b1;
    step();
    cfg_we_i = 1'b0;
    chk("mid_a_valid", 64'(out_valid_o), 64'd1);
    chk("mid_a_result", 64'(result_o), 64'(pk_res(127, 2, 3, 4)));
    chk("mid_clear_wins", 64'(sat_cnt_o), 64'd0);
    in_valid_i = 1'b1;
    data_i = pk_acc(1, 2, 3, 4);
    step();
    in_valid_i = 1'b0;
    chk("mid_b_result", 64'(result_o), 64'(pk_res(5, 6, 7, 8)));
    step();
    chk("mid_gap", 64'(out_valid_o), 64'd0);
    step();
    chk("mid_c_valid", 64'(out_valid_o), 64'd1);
    chk("mid_c_result", 64'(result_o), 64'(pk_res(2, 4, 6, 8)));

    // Saturation counter: 4 clamps per beat, wraps only if it fails to stick.
    cfg(1, 0);
    data_i = pk_acc(1000, -1000, 1000, -1000);
    in_valid_i = 1'b1;
    repeat (16000) step();
    in_valid_i = 1'b0;
    repeat (4) step();
    chk("satcnt_64000", 64'(sat_cnt_o), 64'hFA00);
    in_valid_i = 1'b1;
    repeat (400) step();
    in_valid_i = 1'b0;
    repeat (4) step();
    chk("satcnt_sticky", 64'(sat_cnt_o), 64'hFFFF);

    // Reset with the pipe full: (200*2+1)>>>1 = 200 -> 127, (9*2+1)>>>1 = 9.
    cfg(2, 1);
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    data_i = pk_acc(200, 9, 9, 9);
    repeat (3) step();
    in_valid_i = 1'b0;
    chk("full_valid", 64'(out_valid_o), 64'd1);
    chk("full_result", 64'(result_o), 64'(pk_res(127, 9, 9, 9)));
    chk("full_satcnt", 64'(sat_cnt_o), 64'd1);
    chk("full_in_ready", 64'(in_ready_o), 64'd0);
    rst_n_i = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    chk("arst_result", 64'(result_o), 64'd0);
    chk("arst_satcnt", 64'(sat_cnt_o), 64'd0);
    step();
    rst_n_i = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_beat", 64'(out_valid_o), 64'd0);
    end
    send_check("post_rst", pk_acc(7, -7, 100, -100), pk_res(7, -7, 100, -100), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
